// File: rtl/nios2_irq_pkg.sv
// Shared constants and types for the nios2 interrupt controller:
// register map, FSM encoding and the VECTOR read layout.
package nios2_irq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_PEND   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_RAW    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_VECTOR = 3'd5;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ASSERTED = 2'd1;
  localparam logic [1:0] ST_HOLDOFF  = 2'd2;

  typedef struct packed {
    logic            busy;
    logic            holdoff;
    logic [9:0]      rsvd;
    logic [ID_W-1:0] id;
  } vector_t;

endpackage

// File: rtl/nios2_irq_ctrl_if.sv
// Avalon-MM slave bus between the CPU side and the interrupt controller.
interface nios2_irq_ctrl_if;
  import nios2_irq_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios2_irq_sync.sv
// Multi-stage synchroniser for one asynchronous irq line, with rising-edge detect
// on the synchronised value.
module nios2_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_c_o
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic                   sync_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q    <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      stage_q    <= {stage_q[SYNC_STAGES-2:0], async_i};
      sync_dly_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o   = stage_q[SYNC_STAGES-1];
  assign rise_c_o = stage_q[SYNC_STAGES-1] & ~sync_dly_q;

endmodule

// File: rtl/nios2_irq_ctrl.sv
// Avalon-MM interrupt controller: per-source sync, edge/level pending, mask,
// fixed lowest-index priority, single irq_out with EOI and post-EOI hold-off.
module nios2_irq_ctrl
  import nios2_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter logic [15:0] RESET_MASK     = 16'h0000
) (
  input  logic                clk,
  input  logic                reset_n,
  nios2_irq_ctrl_if.slave     avs,
  input  logic [NUM_SRC-1:0]  irq_in,
  output logic                irq_out,
  output logic [ID_W-1:0]     irq_id
);

  localparam logic [NUM_SRC-1:0] MASK_RST = RESET_MASK[NUM_SRC-1:0];

  logic [NUM_SRC-1:0] sync_w;
  logic [NUM_SRC-1:0] rise_w;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    nios2_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_i  (irq_in[g]),
      .sync_o   (sync_w[g]),
      .rise_c_o (rise_w[g])
    );
  end

  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               irq_out_q, irq_out_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               wr_c;
  logic               wr_pend_c, wr_mask_c, wr_edge_c, eoi_c;
  logic [NUM_SRC-1:0] wdata_c;
  logic [NUM_SRC-1:0] active_c;
  logic [ID_W-1:0]    win_c;
  vector_t            vector_c;
  logic               unused_wdata_c;

  // Lowest set index wins.
  function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
    logic found;
    prio_enc = '0;
    found    = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (v[i] && !found) begin
        prio_enc = ID_W'(i);
        found    = 1'b1;
      end
    end
  endfunction

  assign wr_c           = avs.chipselect & ~avs.write_n;
  assign wr_pend_c      = wr_c && (avs.address == ADDR_PEND);
  assign wr_mask_c      = wr_c && (avs.address == ADDR_MASK);
  assign wr_edge_c      = wr_c && (avs.address == ADDR_EDGE);
  assign eoi_c          = wr_c && (avs.address == ADDR_VECTOR);
  assign wdata_c        = avs.writedata[NUM_SRC-1:0];
  assign unused_wdata_c = ^avs.writedata;
  assign active_c       = pend_q & mask_q;
  assign win_c          = prio_enc(active_c);

  // Config registers and pending; a new edge beats a simultaneous W1C.
  always_comb begin
    mask_d = wr_mask_c ? wdata_c : mask_q;
    edge_d = wr_edge_c ? wdata_c : edge_q;
    pend_d = pend_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (edge_q[i]) pend_d[i] = (pend_q[i] & ~(wr_pend_c & wdata_c[i])) | rise_w[i];
      else           pend_d[i] = sync_w[i];
      if (wr_edge_c && !wdata_c[i]) pend_d[i] = 1'b0;
    end
  end

  // Service FSM; irq_id is frozen while ASSERTED.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    irq_id_d = irq_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|active_c) begin
          state_d  = ST_ASSERTED;
          irq_id_d = win_c;
        end
      end
      ST_ASSERTED: begin
        if (eoi_c) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
          end
        end else if (!(|active_c)) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    irq_out_d = (state_d == ST_ASSERTED);
  end

  // Read mux, registered every cycle regardless of chipselect.
  always_comb begin
    vector_c         = '0;
    vector_c.busy    = (state_q == ST_ASSERTED);
    vector_c.holdoff = (state_q == ST_HOLDOFF);
    vector_c.id      = irq_id_q;
    rdata_d          = '0;
    case (avs.address)
      ADDR_PEND:   rdata_d = DATA_W'(pend_q);
      ADDR_MASK:   rdata_d = DATA_W'(mask_q);
      ADDR_EDGE:   rdata_d = DATA_W'(edge_q);
      ADDR_RAW:    rdata_d = DATA_W'(sync_w);
      ADDR_ACTIVE: rdata_d = DATA_W'(active_c);
      ADDR_VECTOR: rdata_d = vector_c;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= MASK_RST;
      edge_q    <= '0;
      pend_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      irq_id_q  <= '0;
      irq_out_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      irq_id_q  <= irq_id_d;
      irq_out_q <= irq_out_d;
      rdata_q   <= rdata_d;
    end
  end

  assign avs.readdata = rdata_q;
  assign irq_out      = irq_out_q;
  assign irq_id       = irq_id_q;

endmodule

// File: tb/tb_nios2_irq_ctrl.sv
// Directed bench for nios2_irq_ctrl: one instance with a 16-cycle hold-off and
// one with no hold-off; register reads are checked through an expected-value queue.
module tb_nios2_irq_ctrl;
  import nios2_irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irq_in;
  logic [3:0] irq_in1;
  logic       irq_out, irq_out1;
  logic [3:0] irq_id, irq_id1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  nios2_irq_ctrl_if bus0();
  nios2_irq_ctrl_if bus1();

  nios2_irq_ctrl #(
    .NUM_SRC(8), .SYNC_STAGES(2), .HOLDOFF_CYCLES(16), .RESET_MASK(16'hFFF0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .avs(bus0),
    .irq_in(irq_in), .irq_out(irq_out), .irq_id(irq_id)
  );

  nios2_irq_ctrl #(
    .NUM_SRC(4), .SYNC_STAGES(2), .HOLDOFF_CYCLES(0), .RESET_MASK(16'h0001)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .avs(bus1),
    .irq_in(irq_in1), .irq_out(irq_out1), .irq_id(irq_id1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.address = '0; bus0.writedata = '0;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.address = '0; bus1.writedata = '0;
  endtask

  task automatic wr(input int d, input logic [2:0] a, input logic [15:0] v);
    if (d == 0) begin
      bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.address = a; bus0.writedata = v;
    end else begin
      bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.address = a; bus1.writedata = v;
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input int d, input string tag, input logic [2:0] a, input logic [15:0] exp);
    sb_t s;
    if (d == 0) begin
      bus0.chipselect = 1'b1; bus0.write_n = 1'b1; bus0.address = a;
    end else begin
      bus1.chipselect = 1'b1; bus1.write_n = 1'b1; bus1.address = a;
    end
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    bus_idle();
    s = sb_q.pop_front();
    chk(s.tag, (d == 0) ? bus0.readdata : bus1.readdata, s.exp);
  endtask

  initial begin
    irq_in  = '0;
    irq_in1 = '0;
    reset_n = 1'b0;
    bus_idle();
    cyc(2);

    // Reset state
    chk("rst_irq_out", 16'(irq_out), 16'h0);
    chk("rst_irq_id", 16'(irq_id), 16'h0);
    chk("rst_readdata", bus0.readdata, 16'h0);
    reset_n = 1'b1;
    rd(0, "rst_mask", ADDR_MASK, 16'h00F0);
    rd(0, "rst_vector", ADDR_VECTOR, 16'h0000);
    rd(1, "rst_mask1", ADDR_MASK, 16'h0001);

    // Edge source 0: latency, W1C, EOI and 16-cycle hold-off
    wr(0, ADDR_EDGE, 16'h0001);
    wr(0, ADDR_MASK, 16'h0001);
    irq_in[0] = 1'b1;
    cyc(1);
    irq_in[0] = 1'b0;
    cyc(2);
    chk("lat_edge3", 16'(irq_out), 16'h0);
    cyc(1);
    chk("lat_edge4", 16'(irq_out), 16'h1);
    chk("lat_id", 16'(irq_id), 16'h0);
    rd(0, "pend_edge0", ADDR_PEND, 16'h0001);
    wr(0, ADDR_PEND, 16'h0001);
    wr(0, ADDR_VECTOR, 16'h0000);
    chk("eoi_low", 16'(irq_out), 16'h0);
    rd(0, "holdoff_first", ADDR_VECTOR, 16'h4000);
    cyc(14);
    rd(0, "holdoff_last", ADDR_VECTOR, 16'h4000);
    rd(0, "holdoff_done", ADDR_VECTOR, 16'h0000);
    chk("after_holdoff_quiet", 16'(irq_out), 16'h0);

    // Level sources 3 and 5, then higher-priority 1 arrives mid-service
    irq_in[3] = 1'b1;
    irq_in[5] = 1'b1;
    wr(0, ADDR_MASK, 16'h0028);
    cyc(5);
    chk("lvl_out", 16'(irq_out), 16'h1);
    chk("lvl_id3", 16'(irq_id), 16'h3);
    irq_in[1] = 1'b1;
    wr(0, ADDR_MASK, 16'h002A);
    cyc(5);
    chk("hold_out", 16'(irq_out), 16'h1);
    chk("hold_id3", 16'(irq_id), 16'h3);
    rd(0, "raw", ADDR_RAW, 16'h002A);
    rd(0, "active", ADDR_ACTIVE, 16'h002A);
    wr(0, ADDR_VECTOR, 16'h1234);
    chk("eoi2_low", 16'(irq_out), 16'h0);
    cyc(16);
    chk("eoi2_still_low", 16'(irq_out), 16'h0);
    cyc(1);
    chk("reassert_out", 16'(irq_out), 16'h1);
    chk("reassert_id1", 16'(irq_id), 16'h1);
    irq_in = '0;
    cyc(6);
    chk("withdraw_idle", 16'(irq_out), 16'h0);

    // No hold-off: EOI with level source held gives exactly one low cycle
    irq_in1[0] = 1'b1;
    cyc(5);
    chk("h0_out", 16'(irq_out1), 16'h1);
    rd(1, "h0_vector", ADDR_VECTOR, 16'h8000);
    wr(1, ADDR_VECTOR, 16'h0000);
    chk("h0_low", 16'(irq_out1), 16'h0);
    cyc(1);
    chk("h0_reassert", 16'(irq_out1), 16'h1);
    irq_in1 = '0;
    cyc(6);

    // Edge source 2: W1C on the same edge as a new rise keeps the bit set
    wr(0, ADDR_EDGE, 16'h0005);
    irq_in[2] = 1'b1;
    cyc(2);
    wr(0, ADDR_PEND, 16'h0004);
    rd(0, "w1c_vs_rise", ADDR_PEND, 16'h0004);
    wr(0, ADDR_PEND, 16'h0004);
    rd(0, "w1c_clears", ADDR_PEND, 16'h0000);
    irq_in[2] = 1'b0;
    cyc(3);

    // Async reset while ASSERTED
    wr(0, ADDR_MASK, 16'h0008);
    irq_in[3] = 1'b1;
    cyc(5);
    chk("pre_rst_assert", 16'(irq_out), 16'h1);
    #2 reset_n = 1'b0;
    #1 chk("rst_in_asserted", 16'(irq_out), 16'h0);
    irq_in = '0;
    cyc(1);
    reset_n = 1'b1;
    rd(0, "rst1_pend", ADDR_PEND, 16'h0000);
    cyc(6);
    chk("rst1_quiet", 16'(irq_out), 16'h0);

    // Async reset while in HOLDOFF
    irq_in[4] = 1'b1;
    cyc(5);
    chk("pre_holdoff_assert", 16'(irq_out), 16'h1);
    chk("pre_holdoff_id4", 16'(irq_id), 16'h4);
    wr(0, ADDR_VECTOR, 16'h0000);
    cyc(2);
    rd(0, "in_holdoff", ADDR_VECTOR, 16'h4004);
    #2 reset_n = 1'b0;
    #1 chk("rst_in_holdoff", 16'(irq_out), 16'h0);
    irq_in = '0;
    cyc(1);
    reset_n = 1'b1;
    rd(0, "rst2_vector", ADDR_VECTOR, 16'h0000);
    rd(0, "rst2_pend", ADDR_PEND, 16'h0000);
    cyc(6);
    chk("rst2_quiet", 16'(irq_out), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
